mdu_pipe_unit: RTL

- Parametrised multiply/divide unit for the Execute stage of the pipelined CPU; it owns the HI/LO register pair.
- The decoder drives start, op and the HI/LO write enables. Hazard logic stalls the instruction in D while busy is high and an MDU-class instruction is pending.
- It generalises the fixed-latency MDU with configurable data width and per-class latency.
- New over the previous generation: signed/unsigned multiply-accumulate and multiply-subtract, and an abort input for flush/exception.

---
 rtl/mdu_pipe_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mdu_pipe_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pipe_unit
//  Description : Multiply/divide unit owning the HI/LO pair, with fixed
//                per-class latency, multiply-accumulate/subtract and abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_pipe_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MADD  = 3'd4;
    localparam logic [2:0] c_OP_MADDU = 3'd5;

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic                 w_signed;
    logic [2*WIDTH-1:0]   w_a_ext;
    logic [2*WIDTH-1:0]   w_b_ext;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_acc;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic                 w_b_zero;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH-1:0]     w_b_safe;
    logic [WIDTH-1:0]     w_q_mag;
    logic [WIDTH-1:0]     w_r_mag;
    logic [WIDTH-1:0]     w_q;
    logic [WIDTH-1:0]     w_r;
    logic [2*WIDTH-1:0]   w_res;
    logic                 w_res_wr;

    // Even opcodes are the signed variants in every class.
    assign w_signed = ~r_op[0];

    assign w_a_ext = w_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_b_ext = w_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_acc   = {r_hi, r_lo};

    // Sign-magnitude division; the most negative dividend maps to an
    // unsigned magnitude that still fits, so the -2^(W-1)/-1 case wraps.
    assign w_a_neg  = w_signed & r_a[WIDTH-1];
    assign w_b_neg  = w_signed & r_b[WIDTH-1];
    assign w_b_zero = (r_b == '0);
    assign w_a_mag  = w_a_neg ? -r_a : r_a;
    assign w_b_mag  = w_b_neg ? -r_b : r_b;
    assign w_b_safe = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    assign w_q      = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_r      = w_a_neg ? -w_r_mag : w_r_mag;

    always_comb begin
        w_res    = w_prod;
        w_res_wr = 1'b1;
        case (r_op)
            c_OP_MULT, c_OP_MULTU: w_res = w_prod;
            c_OP_DIV, c_OP_DIVU: begin
                w_res    = {w_r, w_q};
                w_res_wr = ~w_b_zero;
            end
            c_OP_MADD, c_OP_MADDU: w_res = w_acc + w_prod;
            default:               w_res = w_acc - w_prod;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= c_CNT_ZERO;
            r_busy <= 1'b0;
            r_op   <= 3'd0;
            r_a    <= '0;
            r_b    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (cancel) begin
            r_cnt  <= c_CNT_ZERO;
            r_busy <= 1'b0;
        end else if (r_cnt != c_CNT_ZERO) begin
            r_cnt  <= r_cnt - c_CNT_ONE;
            r_busy <= (r_cnt != c_CNT_ONE);
            if (r_cnt == c_CNT_ONE && w_res_wr) begin
                r_hi <= w_res[2*WIDTH-1:WIDTH];
                r_lo <= w_res[WIDTH-1:0];
            end
        end else if (start) begin
            r_op   <= op;
            r_a    <= a;
            r_b    <= b;
            r_cnt  <= (op == c_OP_DIV || op == c_OP_DIVU) ? c_DIV_LOAD : c_MULT_LOAD;
            r_busy <= 1'b1;
        end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire
